// File: rtl/fp_command_sequencer.sv
// Front panel command sequencer for a PDP-8 style CPU.
// Accepts panel pulses only while IDLE and turns them into register loads,
// memory deposits, single-step windows and free-run windows.
// It also registers the display mux output and the link bit back to the panel.
module fp_command_sequencer #(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned DEP_TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             loadpc,
    input  logic             loadac,
    input  logic             deposit,
    input  logic             step,
    input  logic             run,
    input  logic [WIDTH-1:0] swreg,
    input  logic [1:0]       dispsel,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] ac_in,
    input  logic [WIDTH-1:0] ma_in,
    input  logic [WIDTH-1:0] mb_in,
    input  logic             link_in,
    input  logic             instr_done,
    input  logic             hlt_exec,
    input  logic             mem_ack,
    output logic             pc_load,
    output logic             ac_load,
    output logic [WIDTH-1:0] reg_data,
    output logic             pc_inc,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             cpu_enable,
    output logic             halt,
    output logic [WIDTH-1:0] dispout,
    output logic             linkout
);

    localparam int unsigned CNT_W = $clog2(DEP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        DEP_REQ,
        DEP_INC
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             pc_load_next, ac_load_next, pc_inc_next;
    logic             mem_req_next, cpu_enable_next, halt_next;
    logic [WIDTH-1:0] reg_data_next, mem_addr_next, mem_wdata_next, disp_next;

    // Next-state and next-output decode; outputs are registered from these.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        pc_load_next    = 1'b0;
        ac_load_next    = 1'b0;
        pc_inc_next     = 1'b0;
        mem_req_next    = 1'b0;
        cpu_enable_next = 1'b0;
        halt_next       = 1'b0;
        reg_data_next   = reg_data;
        mem_addr_next   = mem_addr;
        mem_wdata_next  = mem_wdata;

        case (state)
            IDLE: begin
                if (loadpc) begin
                    pc_load_next  = 1'b1;
                    reg_data_next = swreg;
                end else if (loadac) begin
                    ac_load_next  = 1'b1;
                    reg_data_next = swreg;
                end else if (deposit) begin
                    mem_addr_next  = pc_in;
                    mem_wdata_next = swreg;
                    cnt_next       = '0;
                    mem_req_next   = 1'b1;
                    state_next     = DEP_REQ;
                end else if (step) begin
                    cpu_enable_next = 1'b1;
                    state_next      = STEP;
                end else if (run) begin
                    cpu_enable_next = 1'b1;
                    state_next      = RUN;
                end
            end
            DEP_REQ: begin
                // An ack on the final timeout cycle still wins.
                if (mem_ack) begin
                    pc_inc_next = 1'b1;
                    state_next  = DEP_INC;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next     = cnt + CNT_W'(1);
                    mem_req_next = 1'b1;
                end
            end
            DEP_INC: begin
                state_next = IDLE;
            end
            STEP: begin
                if (instr_done) begin
                    state_next = IDLE;
                end else begin
                    cpu_enable_next = 1'b1;
                end
            end
            RUN: begin
                // Leave only on an instruction boundary.
                if (instr_done && (hlt_exec || !run)) begin
                    halt_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cpu_enable_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Display mux selection.
    always_comb begin
        disp_next = pc_in;
        case (dispsel)
            2'b00:   disp_next = pc_in;
            2'b01:   disp_next = ac_in;
            2'b10:   disp_next = ma_in;
            default: disp_next = mb_in;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            pc_load    <= 1'b0;
            ac_load    <= 1'b0;
            pc_inc     <= 1'b0;
            mem_req    <= 1'b0;
            cpu_enable <= 1'b0;
            halt       <= 1'b0;
            reg_data   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            dispout    <= '0;
            linkout    <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            pc_load    <= pc_load_next;
            ac_load    <= ac_load_next;
            pc_inc     <= pc_inc_next;
            mem_req    <= mem_req_next;
            cpu_enable <= cpu_enable_next;
            halt       <= halt_next;
            reg_data   <= reg_data_next;
            mem_addr   <= mem_addr_next;
            mem_wdata  <= mem_wdata_next;
            dispout    <= disp_next;
            linkout    <= link_in;
        end
    end

endmodule

// File: tb/tb_fp_command_sequencer.sv
// Randomized bench for fp_command_sequencer. Each panel operation is driven as
// a transaction whose expected output waveform is computed from its parameters.
module tb_fp_command_sequencer;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned T     = 15;

    logic             clock = 1'b0;
    logic             reset, loadpc, loadac, deposit, step, run;
    logic [WIDTH-1:0] swreg;
    logic [1:0]       dispsel;
    logic [WIDTH-1:0] pc_in, ac_in, ma_in, mb_in;
    logic             link_in, instr_done, hlt_exec, mem_ack;
    logic             pc_load, ac_load, pc_inc, mem_req, cpu_enable, halt, linkout;
    logic [WIDTH-1:0] reg_data, mem_addr, mem_wdata, dispout;

    always #5 clock = ~clock;

    fp_command_sequencer #(.WIDTH(WIDTH), .DEP_TIMEOUT(T)) dut (
        .clock(clock), .reset(reset), .loadpc(loadpc), .loadac(loadac),
        .deposit(deposit), .step(step), .run(run), .swreg(swreg),
        .dispsel(dispsel), .pc_in(pc_in), .ac_in(ac_in), .ma_in(ma_in),
        .mb_in(mb_in), .link_in(link_in), .instr_done(instr_done),
        .hlt_exec(hlt_exec), .mem_ack(mem_ack), .pc_load(pc_load),
        .ac_load(ac_load), .reg_data(reg_data), .pc_inc(pc_inc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_enable(cpu_enable), .halt(halt), .dispout(dispout),
        .linkout(linkout)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Expected outputs after the next clock edge.
    logic             e_pc_load, e_ac_load, e_pc_inc, e_mem_req, e_cpu_en, e_halt;
    logic             e_chk_reg, e_chk_mem;
    logic [WIDTH-1:0] e_reg, e_addr, e_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic clear_exp();
        e_pc_load = 1'b0; e_ac_load = 1'b0; e_pc_inc = 1'b0;
        e_mem_req = 1'b0; e_cpu_en  = 1'b0; e_halt   = 1'b0;
        e_chk_reg = 1'b0; e_chk_mem = 1'b0;
    endtask

    task automatic quiet();
        loadpc = 1'b0; loadac = 1'b0; deposit = 1'b0; step = 1'b0;
    endtask

    task automatic noise();
        loadpc  = ($urandom_range(0, 3) == 0);
        loadac  = ($urandom_range(0, 3) == 0);
        deposit = ($urandom_range(0, 3) == 0);
        step    = ($urandom_range(0, 3) == 0);
    endtask

    // One clock: capture display inputs, take the edge, compare all outputs.
    task automatic tick();
        logic [WIDTH-1:0] regs [4];
        logic [WIDTH-1:0] e_disp;
        logic             e_link;
        logic             was_reset;
        regs[0] = pc_in; regs[1] = ac_in; regs[2] = ma_in; regs[3] = mb_in;
        was_reset = reset;
        e_disp = was_reset ? '0 : regs[dispsel];
        e_link = was_reset ? 1'b0 : link_in;
        @(posedge clock);
        #1;
        check("pc_load",    32'(pc_load),    32'(e_pc_load));
        check("ac_load",    32'(ac_load),    32'(e_ac_load));
        check("pc_inc",     32'(pc_inc),     32'(e_pc_inc));
        check("mem_req",    32'(mem_req),    32'(e_mem_req));
        check("cpu_enable", 32'(cpu_enable), 32'(e_cpu_en));
        check("halt",       32'(halt),       32'(e_halt));
        check("dispout",    32'(dispout),    32'(e_disp));
        check("linkout",    32'(linkout),    32'(e_link));
        if (e_chk_reg) check("reg_data", 32'(reg_data), 32'(e_reg));
        if (e_chk_mem) begin
            check("mem_addr",  32'(mem_addr),  32'(e_addr));
            check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        end
        pc_in   = WIDTH'($urandom);
        ac_in   = WIDTH'($urandom);
        ma_in   = WIDTH'($urandom);
        mb_in   = WIDTH'($urandom);
        dispsel = 2'($urandom);
        link_in = 1'($urandom);
    endtask

    // loadpc (pc=1) or loadac; extra piles lower-priority commands on top.
    task automatic op_load(input bit pc, input bit extra, input logic [WIDTH-1:0] w);
        quiet();
        loadpc  = pc;
        loadac  = pc ? extra : 1'b1;
        deposit = extra; step = extra; run = extra;
        swreg = w;
        clear_exp();
        if (pc) e_pc_load = 1'b1; else e_ac_load = 1'b1;
        e_reg = w; e_chk_reg = 1'b1;
        tick();
        quiet(); run = 1'b0; swreg = WIDTH'($urandom);
        clear_exp();
        tick();
    endtask

    // Deposit with mem_ack arriving in the d-th request cycle (never if d > T).
    task automatic op_deposit(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] w,
                              input int unsigned d);
        int unsigned last;
        last = (d < T) ? d : T;
        quiet();
        deposit = 1'b1; step = 1'($urandom); run = 1'($urandom);
        pc_in = a; swreg = w; mem_ack = 1'b0;
        clear_exp();
        e_mem_req = 1'b1; e_chk_mem = 1'b1; e_addr = a; e_wdata = w;
        tick();
        for (int unsigned k = 1; k <= last; k++) begin
            noise(); run = 1'b0;
            swreg = WIDTH'($urandom);
            mem_ack = (k == d);
            clear_exp();
            if (k == d) e_pc_inc = 1'b1;
            else if (k < T) begin
                e_mem_req = 1'b1; e_chk_mem = 1'b1;
            end
            tick();
        end
        quiet(); mem_ack = 1'b0;
        clear_exp();
        if (d <= T) tick();
    endtask

    // Single step lasting d cycles; halt must never pulse.
    task automatic op_step(input int unsigned d, input bit hlt);
        quiet();
        step = 1'b1; run = 1'($urandom);
        clear_exp(); e_cpu_en = 1'b1;
        tick();
        for (int unsigned k = 1; k <= d; k++) begin
            noise(); run = 1'b0;
            instr_done = (k == d);
            hlt_exec   = (k == d) ? hlt : 1'($urandom);
            clear_exp();
            if (k < d) e_cpu_en = 1'b1;
            tick();
        end
        quiet(); instr_done = 1'b0; hlt_exec = 1'b0;
        clear_exp();
        tick();
    endtask

    // Free run over n instructions; ends by HLT or by run dropping (drop=1).
    task automatic op_run(input int unsigned n, input bit drop);
        int unsigned lens [8];
        int unsigned total, prev, drop_at, k;
        logic        fin, last;
        total = 0;
        for (int unsigned i = 0; i < n; i++) begin
            lens[i] = $urandom_range(1, 4);
            total += lens[i];
        end
        prev    = total - lens[n-1];
        drop_at = $urandom_range(prev + 1, total);
        quiet(); run = 1'b1;
        clear_exp(); e_cpu_en = 1'b1;
        tick();
        k = 0;
        for (int unsigned i = 0; i < n; i++) begin
            for (int unsigned j = 1; j <= lens[i]; j++) begin
                k++;
                noise();
                last = (j == lens[i]);
                fin  = last && (i == n - 1);
                instr_done = last;
                hlt_exec   = fin ? !drop : (last ? 1'b0 : 1'($urandom));
                run        = (drop && k >= drop_at) ? 1'b0 : 1'b1;
                clear_exp();
                if (fin) e_halt = 1'b1; else e_cpu_en = 1'b1;
                tick();
            end
        end
        quiet(); run = 1'b0; instr_done = 1'b0; hlt_exec = 1'b0;
        clear_exp();
        tick();
    endtask

    // Reset in the middle of a deposit (kind=1) or a run (kind=0).
    task automatic op_reset(input bit kind, input int unsigned r);
        quiet();
        deposit = kind; run = !kind; mem_ack = 1'b0; instr_done = 1'b0;
        swreg = WIDTH'($urandom);
        e_addr = pc_in; e_wdata = swreg;
        for (int unsigned k = 0; k <= r; k++) begin
            clear_exp();
            if (kind) begin
                e_mem_req = 1'b1; e_chk_mem = 1'b1;
            end else e_cpu_en = 1'b1;
            tick();
            deposit = 1'b0; swreg = WIDTH'($urandom);
        end
        reset = 1'b1; run = 1'b0;
        clear_exp();
        e_chk_reg = 1'b1; e_reg = '0;
        e_chk_mem = 1'b1; e_addr = '0; e_wdata = '0;
        tick();
        reset = 1'b0;
        clear_exp();
        tick();
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; instr_done = 1'b0; hlt_exec = 1'b0; mem_ack = 1'b0;
        quiet();
        swreg = '0; dispsel = 2'b00;
        pc_in = '0; ac_in = '0; ma_in = '0; mb_in = '0; link_in = 1'b0;
        clear_exp();
        e_chk_reg = 1'b1; e_reg = '0;
        e_chk_mem = 1'b1; e_addr = '0; e_wdata = '0;
        tick();
        tick();
        reset = 1'b0;
        clear_exp();
        tick();

        op_load(1'b1, 1'b0, 12'o1234);
        op_load(1'b1, 1'b1, 12'o0777);
        op_deposit(12'o0200, 12'o7402, 3);
        op_deposit(WIDTH'($urandom), WIDTH'($urandom), 40);
        op_load(1'b0, 1'b0, WIDTH'($urandom));
        op_deposit(WIDTH'($urandom), WIDTH'($urandom), T);
        op_deposit(WIDTH'($urandom), WIDTH'($urandom), T + 1);
        op_step(5, 1'b1);
        op_run(4, 1'b0);
        op_run(4, 1'b1);
        op_reset(1'b1, 2);
        op_reset(1'b0, 3);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0: op_load(1'($urandom), 1'($urandom), WIDTH'($urandom));
                1: op_deposit(WIDTH'($urandom), WIDTH'($urandom), $urandom_range(1, T + 3));
                2: op_step($urandom_range(1, 8), 1'($urandom));
                3: op_run($urandom_range(1, 6), 1'($urandom));
                4: op_reset(1'($urandom), $urandom_range(0, 5));
                default: op_load(1'b0, 1'b1, WIDTH'($urandom));
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
